match_state_manager: RTL and testbench

Downstream consumer of the MMIO coprocessor cluster's per-player position and damage words. It tracks stocks (lives) for two players and detects blast-zone knockouts. It sequences the match: idle, countdown, play and game over. It drives respawn pulses and a freeze flag back into the physics path, and presents a packed status word for processor readback through the coprocessor read mux.

---
 rtl/match_state_manager.sv | 233 +++++++++++++++++++++++
 tb/tb_match_state_manager.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/match_state_manager.sv
// ============================================================================
// Module      : match_state_manager
// Description : Two-player stock/knockout tracker and match sequencer
//               (idle, countdown, play, game over) with status readback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module match_state_manager #(
  parameter logic [3:0]         STOCKS           = 4'd3,
  parameter logic [23:0]        COUNTDOWN_CYCLES = 24'd12_500_000,
  parameter logic [23:0]        RESPAWN_CYCLES   = 24'd6_250_000,
  parameter logic [7:0]         GRACE_CYCLES     = 8'd4,
  parameter logic signed [15:0] BLAST_X_MIN      = -16'sd64,
  parameter logic signed [15:0] BLAST_X_MAX      = 16'sd704,
  parameter logic signed [15:0] BLAST_Y_MIN      = -16'sd64,
  parameter logic signed [15:0] BLAST_Y_MAX      = 16'sd600
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] pos1_i,
  input  logic [31:0] pos2_i,
  input  logic [31:0] damage1_i,
  input  logic [31:0] damage2_i,
  output logic        respawn1_o,
  output logic        respawn2_o,
  output logic        damage_clr1_o,
  output logic        damage_clr2_o,
  output logic        freeze_o,
  output logic        game_over_o,
  output logic [1:0]  winner_o,
  output logic [31:0] status_o
);

  typedef enum logic [1:0] {
    M_IDLE      = 2'd0,
    M_COUNTDOWN = 2'd1,
    M_PLAYING   = 2'd2,
    M_GAME_OVER = 2'd3
  } match_state_e;

  typedef enum logic [2:0] {
    P_ALIVE   = 3'd0,
    P_KO_WAIT = 3'd1,
    P_RESPAWN = 3'd2,
    P_GRACE   = 3'd3,
    P_OUT     = 3'd4
  } player_state_e;

  // A terminal count of zero behaves as a single cycle.
  function automatic logic [23:0] last_cnt(input logic [23:0] n);
    return (n == 24'd0) ? 24'd0 : n - 24'd1;
  endfunction

  function automatic logic out_of_bounds(input logic [31:0] p);
    logic signed [15:0] x;
    logic signed [15:0] y;
    x = p[31:16];
    y = p[15:0];
    return (x < BLAST_X_MIN) | (x > BLAST_X_MAX) |
           (y < BLAST_Y_MIN) | (y > BLAST_Y_MAX);
  endfunction

  logic                start_q;
  logic [31:0]         pos_q [2];
  match_state_e        m_state_q, m_state_d;
  logic [23:0]         m_cnt_q, m_cnt_d;
  player_state_e       p_state_q [2];
  player_state_e       p_state_d [2];
  logic [23:0]         p_cnt_q [2];
  logic [23:0]         p_cnt_d [2];
  logic [3:0]          stocks_q [2];
  logic [3:0]          stocks_d [2];
  logic [1:0]          respawn_q, respawn_d;
  logic [1:0]          dclr_q, dclr_d;
  logic                freeze_q, freeze_d;
  logic                game_over_q, game_over_d;
  logic [1:0]          winner_q, winner_d;
  logic [31:0]         status_q, status_d;

  logic                start_edge;
  logic                cd_entry;
  logic [1:0]          oob;
  logic [1:0]          zero;
  logic [1:0]          alive;

  // Damage values are informational only.
  logic                unused_damage;
  assign unused_damage = ^{damage1_i, damage2_i};

  assign start_edge = start_i & ~start_q;
  assign oob        = {out_of_bounds(pos_q[1]), out_of_bounds(pos_q[0])};

  always_comb begin
    m_state_d = m_state_q;
    m_cnt_d   = m_cnt_q;
    winner_d  = winner_q;
    cd_entry  = 1'b0;
    zero      = 2'b00;
    alive     = 2'b00;
    respawn_d = 2'b00;
    dclr_d    = 2'b00;

    case (m_state_q)
      M_IDLE, M_GAME_OVER: begin
        if (start_edge) begin
          m_state_d = M_COUNTDOWN;
          m_cnt_d   = 24'd0;
          winner_d  = 2'b00;
          cd_entry  = 1'b1;
        end
      end
      M_COUNTDOWN: begin
        if (m_cnt_q >= last_cnt(COUNTDOWN_CYCLES)) begin
          m_state_d = M_PLAYING;
          m_cnt_d   = 24'd0;
        end else begin
          m_cnt_d = m_cnt_q + 24'd1;
        end
      end
      default: ;
    endcase

    for (int i = 0; i < 2; i++) begin
      p_state_d[i] = p_state_q[i];
      p_cnt_d[i]   = p_cnt_q[i];
      stocks_d[i]  = stocks_q[i];
      if (cd_entry) begin
        p_state_d[i] = P_ALIVE;
        p_cnt_d[i]   = 24'd0;
        stocks_d[i]  = STOCKS;
      end else if (m_state_q == M_PLAYING) begin
        case (p_state_q[i])
          P_ALIVE: begin
            if (oob[i]) begin
              stocks_d[i]  = (stocks_q[i] == 4'd0) ? 4'd0 : stocks_q[i] - 4'd1;
              p_cnt_d[i]   = 24'd0;
              p_state_d[i] = (stocks_d[i] == 4'd0) ? P_OUT : P_KO_WAIT;
            end
          end
          P_KO_WAIT: begin
            if (p_cnt_q[i] >= last_cnt(RESPAWN_CYCLES)) begin
              p_state_d[i] = P_RESPAWN;
              p_cnt_d[i]   = 24'd0;
            end else begin
              p_cnt_d[i] = p_cnt_q[i] + 24'd1;
            end
          end
          P_RESPAWN: begin
            p_state_d[i] = P_GRACE;
            p_cnt_d[i]   = 24'd0;
          end
          P_GRACE: begin
            if (p_cnt_q[i] >= last_cnt({16'd0, GRACE_CYCLES})) begin
              p_state_d[i] = P_ALIVE;
              p_cnt_d[i]   = 24'd0;
            end else begin
              p_cnt_d[i] = p_cnt_q[i] + 24'd1;
            end
          end
          default: ;
        endcase
      end
      zero[i]  = (stocks_d[i] == 4'd0);
      alive[i] = (p_state_d[i] == P_ALIVE) || (p_state_d[i] == P_GRACE);
      // Pulse only on entry so a RESPAWN frozen by game over cannot stick high.
      respawn_d[i] = cd_entry |
                     ((p_state_d[i] == P_RESPAWN) && (p_state_q[i] != P_RESPAWN));
      dclr_d[i]    = respawn_d[i];
    end

    if ((m_state_q == M_PLAYING) && (|zero)) begin
      m_state_d = M_GAME_OVER;
      m_cnt_d   = 24'd0;
      winner_d  = {zero[0], zero[1]};
    end

    freeze_d    = (m_state_d != M_PLAYING);
    game_over_d = (m_state_d == M_GAME_OVER);
    status_d    = {18'd0, winner_d, alive[1], alive[0], m_state_d,
                   stocks_d[1], stocks_d[0]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_q     <= 1'b0;
      m_state_q   <= M_IDLE;
      m_cnt_q     <= 24'd0;
      for (int i = 0; i < 2; i++) begin
        pos_q[i]     <= 32'd0;
        p_state_q[i] <= P_ALIVE;
        p_cnt_q[i]   <= 24'd0;
        stocks_q[i]  <= STOCKS;
      end
      respawn_q   <= 2'b00;
      dclr_q      <= 2'b00;
      freeze_q    <= 1'b1;
      game_over_q <= 1'b0;
      winner_q    <= 2'b00;
      status_q    <= {18'd0, 2'b00, 1'b1, 1'b1, M_IDLE, STOCKS, STOCKS};
    end else begin
      start_q     <= start_i;
      pos_q[0]    <= pos1_i;
      pos_q[1]    <= pos2_i;
      m_state_q   <= m_state_d;
      m_cnt_q     <= m_cnt_d;
      for (int i = 0; i < 2; i++) begin
        p_state_q[i] <= p_state_d[i];
        p_cnt_q[i]   <= p_cnt_d[i];
        stocks_q[i]  <= stocks_d[i];
      end
      respawn_q   <= respawn_d;
      dclr_q      <= dclr_d;
      freeze_q    <= freeze_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      status_q    <= status_d;
    end
  end

  assign respawn1_o    = respawn_q[0];
  assign respawn2_o    = respawn_q[1];
  assign damage_clr1_o = dclr_q[0];
  assign damage_clr2_o = dclr_q[1];
  assign freeze_o      = freeze_q;
  assign game_over_o   = game_over_q;
  assign winner_o      = winner_q;
  assign status_o      = status_q;

endmodule

`default_nettype wire

// File: tb/tb_match_state_manager.sv
// ============================================================================
// Module      : tb_match_state_manager
// Description : Directed self-checking bench for match_state_manager.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_match_state_manager;

  localparam logic [31:0] POS_HOME = 32'h0064_0064;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] pos1_i = POS_HOME;
  logic [31:0] pos2_i = POS_HOME;
  logic [31:0] damage1_i = 32'd0;
  logic [31:0] damage2_i = 32'd0;
  logic        respawn1_o, respawn2_o, damage_clr1_o, damage_clr2_o;
  logic        freeze_o, game_over_o;
  logic [1:0]  winner_o;
  logic [31:0] status_o;

  int n_vec = 0;
  int n_err = 0;

  match_state_manager #(
    .STOCKS           (4'd2),
    .COUNTDOWN_CYCLES (24'd4),
    .RESPAWN_CYCLES   (24'd8),
    .GRACE_CYCLES     (8'd2)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .pos1_i        (pos1_i),
    .pos2_i        (pos2_i),
    .damage1_i     (damage1_i),
    .damage2_i     (damage2_i),
    .respawn1_o    (respawn1_o),
    .respawn2_o    (respawn2_o),
    .damage_clr1_o (damage_clr1_o),
    .damage_clr2_o (damage_clr2_o),
    .freeze_o      (freeze_o),
    .game_over_o   (game_over_o),
    .winner_o      (winner_o),
    .status_o      (status_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] st(input int s1, input int s2, input int ms,
                                     input int a1, input int a2, input int w);
    return {18'd0, w[1:0], a2[0], a1[0], ms[1:0], s2[3:0], s1[3:0]};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_status"}, status_o, st(2, 2, 0, 1, 1, 0));
    check({tag, "_pulses"}, {28'd0, respawn1_o, respawn2_o, damage_clr1_o, damage_clr2_o}, 32'd0);
    check({tag, "_flags"}, {28'd0, freeze_o, game_over_o, winner_o}, 32'h8);
  endtask

  task automatic start_match(input string tag);
    start_i = 1'b1;
    tick();
    check({tag, "_cd_status"}, status_o, st(2, 2, 1, 1, 1, 0));
    check({tag, "_cd_pulses"}, {28'd0, respawn1_o, respawn2_o, damage_clr1_o, damage_clr2_o}, 32'hF);
    start_i = 1'b0;
  endtask

  initial begin
    #12;
    check_reset_outs("reset");
    #4 rst_ni = 1'b1;
    tick();

    // First match: countdown timing
    start_match("m1");
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("cd_freeze", freeze_o, (i < 4));
      if (i == 1)
        check("cd_pulse_len", {30'd0, respawn1_o, respawn2_o}, 32'd0);
    end
    check("play_status", status_o, 32'h0000_0E22);

    // P1 below the bottom blast line, held out through KO_WAIT and into GRACE
    pos1_i = 32'h0160_FFA0;
    tick();
    check("ko_latency", status_o, st(2, 2, 2, 1, 1, 0));
    tick();
    check("ko_p1", status_o, st(1, 2, 2, 0, 1, 0));
    for (int i = 1; i <= 11; i++) begin
      tick();
      check("p1_respawn", {30'd0, respawn1_o, damage_clr1_o}, (i == 8) ? 32'h3 : 32'h0);
      if (i == 9) pos1_i = POS_HOME;
    end
    check("p1_no_rekill", status_o, st(1, 2, 2, 1, 1, 0));

    // Coordinates exactly on the blast lines stay in bounds
    pos1_i = 32'h02C0_00FA;
    pos2_i = 32'h0064_0258;
    repeat (3) tick();
    check("edge_max", status_o, st(1, 2, 2, 1, 1, 0));
    pos1_i = 32'hFFC0_FFC0;
    repeat (3) tick();
    check("edge_min", status_o, st(1, 2, 2, 1, 1, 0));
    pos1_i = POS_HOME;

    // P2 one past the right line
    pos2_i = 32'h02C1_00FA;
    tick();
    pos2_i = POS_HOME;
    tick();
    check("ko_p2_x705", status_o, st(1, 1, 2, 1, 0, 0));
    for (int i = 1; i <= 11; i++) begin
      tick();
      check("p2_respawn", {30'd0, respawn2_o, damage_clr2_o}, (i == 8) ? 32'h3 : 32'h0);
    end
    check("p2_back", status_o, st(1, 1, 2, 1, 1, 0));

    // P2 over the top line on its last stock
    pos2_i = 32'h0064_02BC;
    tick();
    pos2_i = POS_HOME;
    tick();
    check("go_status", status_o, 32'h0000_1701);
    check("go_flags", {28'd0, freeze_o, game_over_o, winner_o}, 32'hD);
    repeat (3) tick();
    check("go_hold", status_o, 32'h0000_1701);
    check("go_no_pulse", {30'd0, respawn1_o, respawn2_o}, 32'd0);

    // Restart from GAME_OVER; a start edge during countdown is ignored
    start_match("m2");
    tick();
    start_i = 1'b1;
    tick();
    check("cd_start_ignored", {30'd0, respawn1_o, status_o[9:8]}, 32'h1);
    start_i = 1'b0;
    tick();
    tick();
    check("m2_play", status_o, 32'h0000_0E22);

    // Simultaneous KOs: first to 1/1, then to 0/0 for a draw
    pos1_i = 32'hFFBF_0064;
    pos2_i = 32'h0064_FFBF;
    tick();
    pos1_i = POS_HOME;
    pos2_i = POS_HOME;
    tick();
    check("dual_ko", status_o, st(1, 1, 2, 0, 0, 0));
    for (int i = 1; i <= 11; i++) begin
      tick();
      check("dual_respawn", {30'd0, respawn1_o, respawn2_o}, (i == 8) ? 32'h3 : 32'h0);
    end
    check("dual_back", status_o, st(1, 1, 2, 1, 1, 0));
    pos1_i = 32'h0064_0259;
    pos2_i = 32'hFF9C_0064;
    tick();
    pos1_i = POS_HOME;
    pos2_i = POS_HOME;
    tick();
    check("draw_status", status_o, st(0, 0, 3, 0, 0, 3));
    check("draw_winner", {30'd0, winner_o}, 32'h3);

    // Reset asserted mid KO_WAIT
    start_match("m3");
    repeat (4) tick();
    check("m3_play", status_o, 32'h0000_0E22);
    pos1_i = 32'h0160_FFA0;
    tick();
    pos1_i = POS_HOME;
    tick();
    repeat (3) tick();
    check("m3_ko_wait", status_o, st(1, 2, 2, 0, 1, 0));
    #3 rst_ni = 1'b0;
    #1;
    check_reset_outs("async_rst");
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_no_respawn", {30'd0, respawn1_o, damage_clr1_o}, 32'd0);
    end
    #2 rst_ni = 1'b1;
    tick();
    start_match("m4");
    repeat (4) tick();
    check("m4_play", status_o, 32'h0000_0E22);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
